// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: trap codes seen by the decoder, fetch FSM
// state encodings and the entry format carried by the output and skid registers.
package instruction_fetch_pkg;

  localparam logic [7:0] TRAP_NONE            = 8'h00;
  localparam logic [7:0] TRAP_STALL           = 8'h01;
  localparam logic [7:0] TRAP_BAD_INSTRUCTION = 8'h02;
  localparam logic [7:0] TRAP_SYSCALL         = 8'h03;
  localparam logic [7:0] TRAP_FETCH_FAULT     = 8'h04;
  localparam logic [7:0] TRAP_FETCH_MISALIGN  = 8'h05;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [7:0]  exc;
  } fetch_entry_t;

  function automatic fetch_entry_t bubble_entry();
    fetch_entry_t e;
    e.ins = 32'h0;
    e.pc  = 32'h0;
    e.exc = TRAP_STALL;
    return e;
  endfunction

endpackage

// File: rtl/instruction_fetch_skid.sv
// Single-entry holding register for a fetch response that lands while decode is stalled.
// Clear wins over load so a redirect always drops a parked response.
module fetch_skid_buffer
  import instruction_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  fetch_entry_t load_entry,
  output logic         vld,
  output fetch_entry_t entry
);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      vld   <= 1'b0;
      entry <= bubble_entry();
    end else if (load) begin
      vld   <= 1'b1;
      entry <= load_entry;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: one outstanding imem read, one-cycle ack-to-ir latency,
// stall-tolerant via a single skid entry, redirect/flush handling and fetch traps.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  output logic [7:0]  exception_out
);

  logic [1:0]   state;
  logic [31:0]  pc;
  logic [31:0]  flush_addr;
  logic         armed;
  fetch_entry_t out_q;
  logic         out_vld;

  logic         acked;
  logic         hold_out;
  logic         misaligned;
  fetch_entry_t fetched;
  logic         skid_load;
  logic         skid_clear;
  logic         skid_vld;
  fetch_entry_t skid_q;

  // armed keeps the bus quiet for the first cycle out of reset so a late ack
  // from an abandoned pre-reset request can never be taken.
  assign imem_req   = armed && (state == ST_FETCH || state == ST_FLUSH);
  assign imem_addr  = (state == ST_FLUSH) ? flush_addr : pc;
  assign acked      = imem_ack && imem_req;
  assign hold_out   = stall && out_vld;
  assign misaligned = redirect_pc[1:0] != 2'b00;

  always_comb begin
    fetched.ins = imem_err ? 32'h0 : imem_rdata;
    fetched.pc  = pc;
    fetched.exc = imem_err ? TRAP_FETCH_FAULT : TRAP_NONE;
  end

  assign skid_load  = !redirect_en && state == ST_FETCH && acked && hold_out;
  assign skid_clear = redirect_en || (state == ST_HOLD && !stall);

  fetch_skid_buffer u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .clear      (skid_clear),
    .load_entry (fetched),
    .vld        (skid_vld),
    .entry      (skid_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_FETCH;
      pc         <= RESET_VECTOR;
      flush_addr <= RESET_VECTOR;
      armed      <= 1'b0;
      out_q      <= bubble_entry();
      out_vld    <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (redirect_en) begin
        pc      <= redirect_pc;
        out_vld <= 1'b0;
        if (misaligned) begin
          out_q.ins <= 32'h0;
          out_q.pc  <= redirect_pc;
          out_q.exc <= TRAP_FETCH_MISALIGN;
          state     <= ST_FAULT;
        end else begin
          out_q <= bubble_entry();
          // An unacked read must keep its address on the bus; drain it first.
          if (imem_req && !imem_ack) begin
            state <= ST_FLUSH;
            if (state != ST_FLUSH) flush_addr <= pc;
          end else begin
            state <= ST_FETCH;
          end
        end
      end else begin
        case (state)
          ST_FETCH: begin
            if (acked) begin
              if (!imem_err) pc <= pc + 32'd4;
              if (hold_out) begin
                state <= ST_HOLD;
              end else begin
                out_q   <= fetched;
                out_vld <= !imem_err;
                if (imem_err) state <= ST_FAULT;
              end
            end else if (!hold_out) begin
              out_q   <= bubble_entry();
              out_vld <= 1'b0;
            end
          end
          ST_HOLD: begin
            if (!stall) begin
              out_q   <= skid_vld ? skid_q : bubble_entry();
              out_vld <= skid_vld && skid_q.exc == TRAP_NONE;
              state   <= (skid_vld && skid_q.exc != TRAP_NONE) ? ST_FAULT : ST_FETCH;
            end
          end
          ST_FLUSH: begin
            if (acked) state <= ST_FETCH;
          end
          default: begin
            state <= ST_FAULT;
          end
        endcase
      end
    end
  end

  assign ir            = out_q.ins;
  assign ir_pc         = out_q.pc;
  assign ir_valid      = out_vld;
  assign exception_out = out_q.exc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized stall/redirect/latency,
// checked against an instruction-stream model (expected next pc, fault and hold rules).
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic [7:0]  exception_out;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_VECTOR(RV)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .imem_err      (imem_err),
    .stall         (stall),
    .redirect_en   (redirect_en),
    .redirect_pc   (redirect_pc),
    .ir            (ir),
    .ir_pc         (ir_pc),
    .ir_valid      (ir_valid),
    .exception_out (exception_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic logic is_err(input logic [31:0] a);
    return a[7:2] == 6'h10;
  endfunction

  // Stream model: which instruction must come next, and whether fetch is halted.
  logic [31:0] exp_pc = RV;
  logic        in_fault = 1'b0;
  int          delivered = 0;

  // Inputs/outputs as they stood at the last clock edge.
  logic        p_hold, p_redir, p_req, p_ack, p_rst, p_irv;
  logic [31:0] p_rpc, p_addr, p_ir, p_irpc;
  logic [7:0]  p_exc;

  // Memory responder.
  int          fixed_lat = 0;
  logic        junk = 1'b0;
  logic        mem_new = 1'b1;
  int          mem_age = 0;
  int          mem_lat = 0;
  logic [31:0] mem_addr = 32'h0;
  int          guard;
  logic [31:0] held_pc;

  task automatic model_check();
    if (!p_rst) begin
      check_eq("rst_ir", ir, 32'h0);
      check_eq("rst_ir_pc", ir_pc, 32'h0);
      check_eq("rst_ir_valid", ir_valid, 0);
      check_eq("rst_exc", exception_out, TRAP_STALL);
      check_eq("rst_req", imem_req, 0);
      exp_pc   = RV;
      in_fault = 1'b0;
    end else if (p_redir) begin
      if (p_rpc[1:0] != 2'b00) begin
        check_eq("misal_ir", ir, 32'h0);
        check_eq("misal_ir_pc", ir_pc, p_rpc);
        check_eq("misal_valid", ir_valid, 0);
        check_eq("misal_exc", exception_out, TRAP_FETCH_MISALIGN);
        check_eq("misal_req", imem_req, 0);
        in_fault = 1'b1;
      end else begin
        check_eq("redir_bubble_valid", ir_valid, 0);
        check_eq("redir_bubble_exc", exception_out, TRAP_STALL);
        check_eq("redir_bubble_ir", ir, 32'h0);
        in_fault = 1'b0;
        exp_pc   = p_rpc;
      end
    end else if (in_fault || p_hold) begin
      check_eq("held_ir", ir, p_ir);
      check_eq("held_ir_pc", ir_pc, p_irpc);
      check_eq("held_valid", ir_valid, p_irv);
      check_eq("held_exc", exception_out, p_exc);
      if (in_fault) check_eq("fault_req", imem_req, 0);
    end else if (ir_valid) begin
      check_eq("stream_pc", ir_pc, exp_pc);
      check_eq("stream_ir", ir, mem_word(exp_pc));
      check_eq("stream_exc", exception_out, TRAP_NONE);
      check_eq("stream_not_err_addr", is_err(ir_pc), 0);
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end else if (exception_out == TRAP_FETCH_FAULT) begin
      check_eq("fault_pc", ir_pc, exp_pc);
      check_eq("fault_ir", ir, 32'h0);
      check_eq("fault_at_err_addr", is_err(exp_pc), 1);
      in_fault = 1'b1;
    end else begin
      check_eq("bubble_exc", exception_out, TRAP_STALL);
      check_eq("bubble_ir", ir, 32'h0);
    end
    // An unacked request must stay on the bus unchanged.
    if (p_rst && p_req && !p_ack && !(p_redir && p_rpc[1:0] != 2'b00)) begin
      check_eq("req_stable", imem_req, 1);
      check_eq("addr_stable", imem_addr, p_addr);
    end
    if (imem_req) check_eq("addr_aligned", {30'h0, imem_addr[1:0]}, 32'h0);
  endtask

  task automatic mem_drive();
    if (junk && !imem_req) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      imem_err   = 1'($urandom_range(0, 1));
      mem_new    = 1'b1;
    end else if (imem_req) begin
      if (mem_new || imem_addr != mem_addr) begin
        mem_lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 2));
        mem_age  = 0;
        mem_addr = imem_addr;
      end
      mem_new = 1'b0;
      if (mem_age == mem_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        imem_err   = is_err(imem_addr);
        mem_new    = 1'b1;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        imem_err   = 1'b0;
        mem_age++;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      imem_err   = 1'($urandom_range(0, 1));
      mem_new    = 1'b1;
    end
  endtask

  task automatic tick();
    p_hold  = stall && ir_valid;
    p_redir = redirect_en;
    p_rpc   = redirect_pc;
    p_req   = imem_req;
    p_ack   = imem_ack;
    p_addr  = imem_addr;
    p_rst   = rst;
    p_ir    = ir;
    p_irpc  = ir_pc;
    p_irv   = ir_valid;
    p_exc   = exception_out;
    @(posedge clk);
    #1;
    model_check();
    mem_drive();
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_en = 1'b1;
    redirect_pc = target;
    tick();
    redirect_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; imem_err = 1'b0;

    // Reset release and back-to-back same-cycle acks.
    repeat (3) tick();
    rst = 1'b1;
    check_eq("req_at_release", imem_req, 0);
    tick();
    check_eq("first_req", imem_req, 1);
    check_eq("first_addr", imem_addr, RV);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("seq_pc", ir_pc, RV + 32'(4 * k));
      check_eq("seq_valid", ir_valid, 1);
      check_eq("seq_exc", exception_out, TRAP_NONE);
    end

    // Stall for three cycles while the next ack lands in the skid.
    held_pc = ir_pc;
    stall = 1'b1;
    repeat (3) begin
      tick();
      check_eq("stall_hold_pc", ir_pc, held_pc);
    end
    stall = 1'b0;
    tick();
    check_eq("after_stall_pc", ir_pc, held_pc + 32'd4);
    check_eq("after_stall_valid", ir_valid, 1);

    // Redirect to 0x100 while the 0x20 read waits two cycles for its ack.
    fixed_lat = 2;
    redirect_to(32'h20);
    guard = 0;
    while (!(imem_req && imem_addr == 32'h20) && guard < 10) begin tick(); guard++; end
    check_eq("req_0x20_seen", imem_req && imem_addr == 32'h20, 1);
    redirect_to(32'h100);
    check_eq("flush_bubble_exc", exception_out, TRAP_STALL);
    guard = 0;
    while (!ir_valid && guard < 20) begin tick(); guard++; end
    check_eq("after_flush_pc", ir_pc, 32'h100);
    check_eq("after_flush_ir", ir, mem_word(32'h100));

    // Misaligned redirect halts fetch until an aligned redirect.
    fixed_lat = 0;
    redirect_to(32'h102);
    check_eq("misal_exc_d", exception_out, TRAP_FETCH_MISALIGN);
    check_eq("misal_pc_d", ir_pc, 32'h102);
    repeat (3) begin
      tick();
      check_eq("misal_held_exc", exception_out, TRAP_FETCH_MISALIGN);
      check_eq("misal_no_req", imem_req, 0);
    end
    redirect_to(32'h200);
    guard = 0;
    while (!ir_valid && guard < 20) begin tick(); guard++; end
    check_eq("resume_pc", ir_pc, 32'h200);

    // Bus error on 0x40.
    redirect_to(32'h38);
    guard = 0;
    while (exception_out != TRAP_FETCH_FAULT && guard < 20) begin tick(); guard++; end
    check_eq("err_exc", exception_out, TRAP_FETCH_FAULT);
    check_eq("err_pc", ir_pc, 32'h40);
    check_eq("err_valid", ir_valid, 0);
    repeat (3) begin
      tick();
      check_eq("err_no_req", imem_req, 0);
      check_eq("err_held_exc", exception_out, TRAP_FETCH_FAULT);
    end

    // Address wrap at the top of the space.
    redirect_to(32'hFFFF_FFF8);
    guard = 0;
    while (!(ir_valid && ir_pc == 32'hFFFF_FFFC) && guard < 20) begin tick(); guard++; end
    check_eq("wrap_seen", ir_valid && ir_pc == 32'hFFFF_FFFC, 1);
    check_eq("wrap_req", imem_req, 1);
    check_eq("wrap_addr", imem_addr, 32'h0);

    // Reset in the middle of a slow read, with stray acks around the release.
    fixed_lat = 2;
    repeat (2) tick();
    rst = 1'b0;
    junk = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    junk = 1'b0;
    fixed_lat = 0;
    guard = 0;
    while (!ir_valid && guard < 20) begin tick(); guard++; end
    check_eq("post_rst_pc", ir_pc, RV);
    check_eq("post_rst_ir", ir, mem_word(RV));

    // Randomized stalls, redirects and memory latency.
    fixed_lat = -1;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, in_fault ? 3 : 24) == 0) begin
        redirect_en = 1'b1;
        case ($urandom_range(0, 15))
          0:       redirect_pc = 32'hFFFF_FFF0;
          1, 2:    redirect_pc = {23'h0, 7'($urandom_range(0, 127)), 2'($urandom_range(1, 3))};
          default: redirect_pc = {23'h0, 7'($urandom_range(0, 127)), 2'b00};
        endcase
      end else begin
        redirect_en = 1'b0;
      end
      tick();
    end
    redirect_en = 1'b0;
    stall = 1'b0;
    check_eq("random_liveness", delivered >= 300, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: PC loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 imem_req  out  1  instruction memory read request.
REQ-005 imem_addr  out  32  word-aligned fetch address; valid while imem_req=1.
REQ-006 imem_ack  in  1  read complete this cycle; imem_rdata/imem_err valid.
REQ-007 imem_rdata  in  32  fetched instruction word.
REQ-008 imem_err  in  1  bus fault on the acked read.
REQ-009 stall  in  1  decode stage cannot accept a new instruction; hold outputs.
REQ-010 redirect_en  in  1  branch/jump/trap resolved; refetch from redirect_pc.
REQ-011 redirect_pc  in  32  new fetch address.
REQ-012 ir  out  32  instruction word to the decoder.
REQ-013 ir_pc  out  32  address of ir.
REQ-014 ir_valid  out  1  ir holds a real instruction.
REQ-015 exception_out  out  8  feeds decoder exception_in; 0 = none.

Function
REQ-016 States: FETCH (request outstanding), HOLD (valid output, stall=1, no request), FLUSH (discarding stale response), FAULT (halted, no request).
REQ-017 FETCH: imem_req=1, imem_addr=pc; imem_addr SHALL be stable from assertion until the cycle imem_ack=1.
REQ-018 On imem_ack with imem_err=0, no redirect: next cycle ir=imem_rdata, ir_pc=pc, ir_valid=1, exception_out=0, pc=pc+4 (mod 2^32, wraps FFFF_FFFC->0).
REQ-019 Latency: one cycle from ack to ir; with same-cycle ack, sustained throughput one instruction per cycle.
REQ-020 stall=1 with ir_valid=1: ir/ir_pc/ir_valid/exception_out held; an in-flight request completes and its data is buffered in a single skid register; no further request until stall=0 (state HOLD).
REQ-021 stall deassert: skid data (if any) presented next cycle, else request resumes same cycle.
REQ-022 When no instruction is presented: ir=0, ir_valid=0, exception_out=TRAP_STALL (bubble).
REQ-023 redirect_en has priority over stall, ack and FAULT; pc=redirect_pc; skid and output invalidated (bubble next cycle).
REQ-024 Redirect with request outstanding and no ack this cycle: enter FLUSH, keep old address until ack, discard data/err, then request redirect_pc.
REQ-025 Redirect in the same cycle as ack: acked data discarded, no FLUSH; next request uses redirect_pc.
REQ-026 Redirect during FLUSH: latest redirect_pc wins; remain in FLUSH.
REQ-027 redirect_pc[1:0]!=0: no memory request; next cycle ir=0, ir_pc=redirect_pc, exception_out=TRAP_FETCH_MISALIGN; enter FAULT.
REQ-028 imem_ack with imem_err=1: ir=0, ir_pc=pc, exception_out=TRAP_FETCH_FAULT; enter FAULT; pc not incremented.
REQ-029 FAULT: exception output held until redirect_en; imem_req=0.

Reset
REQ-030 rst=0 at posedge: pc=RESET_VECTOR, state=FETCH with imem_req=0 that cycle, skid empty, ir=0, ir_pc=0, ir_valid=0, exception_out=TRAP_STALL.
REQ-031 First request issued the cycle after rst returns to 1.
REQ-032 Reset mid-request abandons it; a late imem_ack after reset SHALL be ignored until the new request is issued.

Structure
REQ-033 TRAP_* codes (existing TRAP_STALL, TRAP_BAD_INSTRUCTION, TRAP_SYSCALL plus new TRAP_FETCH_FAULT, TRAP_FETCH_MISALIGN) and state encodings live in the shared defines header.
REQ-034 One sub-module: fetch_skid_buffer (single-entry data+pc+exception buffer with valid flag).

Verification
REQ-035 Reset release, memory acks same cycle, stall=0 -> ir_pc 0,4,8,12 on consecutive cycles, ir_valid=1, exception_out=0.
REQ-036 stall=1 for 3 cycles while ack arrives -> ir held, no lost/duplicated instruction; after release next ir_pc=previous+4.
REQ-037 redirect_en to 0x100 while request to 0x20 pending, ack 2 cycles later -> 0x20 data discarded, one bubble (TRAP_STALL), next ir_pc=0x100.
REQ-038 redirect_pc=0x102 -> no imem_req, exception_out=TRAP_FETCH_MISALIGN held until redirect to 0x200, then ir_pc=0x200.
REQ-039 imem_err=1 on fetch of 0x40 -> exception_out=TRAP_FETCH_FAULT, ir_pc=0x40, imem_req=0 until redirect.
REQ-040 pc=FFFF_FFFC fetched -> next imem_addr=0000_0000.
